// File: rtl/hit_rpt_pkg.sv
// rtl/hit_rpt_pkg.sv - shared constants and FSM encoding for the hit reporter
// Contents: DEF_WIN_W / DEF_CNT_W / DEF_DEPTH parameter defaults, state_t (IDLE, RUN).
package hit_rpt_pkg;

  localparam int DEF_WIN_W = 8;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_DEPTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/hit_reporter_if.sv
// rtl/hit_reporter_if.sv - report stream handshake between hit_reporter and its consumer
// Signals: rpt_valid (report available), rpt_ready (consumer accepts), rpt_data (window hit count).
// Modports: master = report producer, slave = report consumer.
interface hit_reporter_if
  import hit_rpt_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             rpt_valid;
  logic             rpt_ready;
  logic [CNT_W-1:0] rpt_data;

  modport master (output rpt_valid, output rpt_data, input rpt_ready);
  modport slave  (input rpt_valid, input rpt_data, output rpt_ready);

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO holding window reports
// Ports: clk, reset_n (sync, active-low), push/wr_data (write), pop/rd_data (read head),
//        full, empty, level (occupancy 0..DEPTH).
module sync_fifo
  import hit_rpt_pkg::*;
#(
  parameter int WIDTH = DEF_CNT_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  // When full, a write is only accepted if the head leaves in the same cycle;
  // wr_ptr == rd_ptr then, and the head is read before the edge overwrites it.
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers are AW bits wide, so DEPTH being a power of two makes them wrap for free.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW + 1)'(1);
        2'b01:   level <= level - (AW + 1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/hit_reporter.sv
// rtl/hit_reporter.sv - counts detector hits per fixed-length window and queues the counts
// Ports: clk, reset_n (sync, active-low), hit (detect pulse), enable (run windows),
//        win_len (window length - 1), clr_ovf (clear sticky overflow),
//        rpt (hit_reporter_if.master: rpt_valid/rpt_ready/rpt_data),
//        level (FIFO occupancy), ovf (sticky: a report was dropped).
module hit_reporter
  import hit_rpt_pkg::*;
#(
  parameter int WIN_W = DEF_WIN_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   hit,
  input  logic                   enable,
  input  logic [WIN_W-1:0]       win_len,
  input  logic                   clr_ovf,
  hit_reporter_if.master         rpt,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf
);

  state_t           state;
  logic [WIN_W-1:0] win_cnt;
  logic [WIN_W-1:0] win_lat;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] hit_next;
  logic             close;
  logic             pop;
  logic             full;
  logic             empty;
  logic             drop;

  // Saturating count including this cycle's hit; this is also the record pushed at close.
  assign hit_next = (hit && (hit_cnt != '1)) ? hit_cnt + CNT_W'(1) : hit_cnt;

  // A cycle where enable has fallen is the RUN-to-IDLE cycle and never closes a window.
  assign close = (state == RUN) && enable && (win_cnt == win_lat);
  assign pop   = rpt.rpt_valid && rpt.rpt_ready;
  assign drop  = close && full && !pop;

  assign rpt.rpt_valid = !empty;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      win_cnt <= '0;
      win_lat <= '0;
      hit_cnt <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          win_cnt <= '0;
          hit_cnt <= '0;
          if (enable) begin
            state   <= RUN;
            win_lat <= win_len;
          end
        end
        RUN: begin
          if (!enable) begin
            state   <= IDLE;
            win_cnt <= '0;
            hit_cnt <= '0;
          end else if (close) begin
            win_cnt <= '0;
            hit_cnt <= '0;
            win_lat <= win_len;
          end else begin
            win_cnt <= win_cnt + WIN_W'(1);
            hit_cnt <= hit_next;
          end
        end
      endcase
      // A drop in the same cycle as clr_ovf wins so the event is never lost.
      if (drop) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

  sync_fifo #(
    .WIDTH (CNT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (close),
    .wr_data (hit_next),
    .pop     (pop),
    .rd_data (rpt.rpt_data),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

endmodule

// File: tb/tb_hit_reporter.sv
// tb/tb_hit_reporter.sv - self-checking bench for hit_reporter
module tb_hit_reporter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       hit;
  logic       enable;
  logic [7:0] win_len;
  logic       clr_ovf;
  logic [2:0] level;
  logic       ovf;

  hit_reporter_if #(.CNT_W(8)) rpt ();

  hit_reporter #(.WIN_W(8), .CNT_W(8), .DEPTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .hit     (hit),
    .enable  (enable),
    .win_len (win_len),
    .clr_ovf (clr_ovf),
    .rpt     (rpt),
    .level   (level),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] sb [$];
  logic [7:0] exp_d;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; hit = 1'b0; enable = 1'b0; win_len = 8'd0;
    clr_ovf = 1'b0; rpt.rpt_ready = 1'b0;
    tick; tick;
    n_checks++; if (rpt.rpt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", rpt.rpt_valid); end
    n_checks++; if (rpt.rpt_data !== 8'd0) begin n_fail++; $display("FAIL reset_data got %0d want 0", rpt.rpt_data); end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf); end
    reset_n = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    win_len = 8'd3; rpt.rpt_ready = 1'b1; hit = 1'b0; enable = 1'b1;
    sb.push_back(8'd2);
    sb.push_back(8'd0);
    tick;  // IDLE->RUN, not counted
    for (int c = 0; c < 4; c++) begin
      hit = (c == 1 || c == 3);
      tick;
    end
    hit = 1'b0;
    exp_d = sb.pop_front();
    n_checks++; if (rpt.rpt_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency_valid got %b want 1", rpt.rpt_valid); end
    n_checks++; if (rpt.rpt_data !== exp_d) begin n_fail++; $display("FAIL basic_count got %0d want %0d", rpt.rpt_data, exp_d); end
    for (int c = 0; c < 4; c++) tick;
    exp_d = sb.pop_front();
    n_checks++; if (rpt.rpt_valid !== 1'b1) begin n_fail++; $display("FAIL basic_second_valid got %b want 1", rpt.rpt_valid); end
    n_checks++; if (rpt.rpt_data !== exp_d) begin n_fail++; $display("FAIL basic_second_count got %0d want %0d", rpt.rpt_data, exp_d); end
    enable = 1'b0;
    tick;
    n_checks++; if (rpt.rpt_valid !== 1'b0 || level !== 3'd0) begin n_fail++; $display("FAIL basic_drain valid %b level %0d want 0 0", rpt.rpt_valid, level); end
  endtask

  task automatic test_saturate;
    win_len = 8'd255; rpt.rpt_ready = 1'b1; hit = 1'b1; enable = 1'b1;
    sb.push_back(8'd255);
    tick;
    for (int c = 0; c < 256; c++) begin
      if (c == 255) begin
        n_checks++; if (rpt.rpt_valid !== 1'b0) begin n_fail++; $display("FAIL sat_early_close got valid %b want 0", rpt.rpt_valid); end
      end
      tick;
    end
    exp_d = sb.pop_front();
    n_checks++; if (rpt.rpt_valid !== 1'b1 || rpt.rpt_data !== exp_d) begin n_fail++; $display("FAIL sat_count got valid %b data %0d want 1 %0d", rpt.rpt_valid, rpt.rpt_data, exp_d); end
    enable = 1'b0; hit = 1'b0;
    tick;
  endtask

  task automatic test_overflow;
    win_len = 8'd0; rpt.rpt_ready = 1'b0; hit = 1'b1; enable = 1'b1;
    tick;
    for (int w = 0; w < 4; w++) begin
      sb.push_back(8'd1);
      tick;
    end
    n_checks++; if (level !== 3'd4 || ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_fill level %0d ovf %b want 4 0", level, ovf); end
    clr_ovf = 1'b1;  // same cycle as the fifth (dropped) window
    tick;
    n_checks++; if (ovf !== 1'b1 || level !== 3'd4) begin n_fail++; $display("FAIL ovf_drop_priority ovf %b level %0d want 1 4", ovf, level); end
    enable = 1'b0;
    tick;
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", ovf); end
    clr_ovf = 1'b0; enable = 1'b1;
    tick;
    rpt.rpt_ready = 1'b1;
    exp_d = sb.pop_front();
    n_checks++; if (rpt.rpt_valid !== 1'b1 || rpt.rpt_data !== exp_d) begin n_fail++; $display("FAIL ovf_head got valid %b data %0d want 1 %0d", rpt.rpt_valid, rpt.rpt_data, exp_d); end
    sb.push_back(8'd1);
    tick;
    n_checks++; if (level !== 3'd4 || ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_push_pop_full level %0d ovf %b want 4 0", level, ovf); end
    enable = 1'b0; hit = 1'b0;
    for (int i = 0; i < 12 && (sb.size() != 0 || rpt.rpt_valid); i++) begin
      if (rpt.rpt_valid) begin
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL ovf_extra_report got %0d want none", rpt.rpt_data); end
        else begin
          exp_d = sb.pop_front();
          if (rpt.rpt_data !== exp_d) begin n_fail++; $display("FAIL ovf_read got %0d want %0d", rpt.rpt_data, exp_d); end
        end
      end
      tick;
    end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL ovf_missing_reports got %0d left want 0", sb.size()); end
  endtask

  task automatic test_order;
    logic [1:0] pat [3];
    pat[0] = 2'b11; pat[1] = 2'b00; pat[2] = 2'b10;
    win_len = 8'd1; rpt.rpt_ready = 1'b0; hit = 1'b0; enable = 1'b1;
    tick;
    for (int w = 0; w < 3; w++) begin
      sb.push_back(8'($countones(pat[w])));
      for (int c = 0; c < 2; c++) begin
        hit = pat[w][c];
        tick;
      end
    end
    enable = 1'b0; hit = 1'b0;
    tick;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (rpt.rpt_valid !== 1'b1 || rpt.rpt_data !== sb[0]) begin n_fail++; $display("FAIL order_hold got valid %b data %0d want 1 %0d", rpt.rpt_valid, rpt.rpt_data, sb[0]); end
      tick;
    end
    rpt.rpt_ready = 1'b1;
    for (int i = 0; i < 10 && (sb.size() != 0 || rpt.rpt_valid); i++) begin
      if (rpt.rpt_valid) begin
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL order_extra_report got %0d want none", rpt.rpt_data); end
        else begin
          exp_d = sb.pop_front();
          if (rpt.rpt_data !== exp_d) begin n_fail++; $display("FAIL order_read got %0d want %0d", rpt.rpt_data, exp_d); end
        end
      end
      tick;
    end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL order_missing_reports got %0d left want 0", sb.size()); end
    n_checks++; if (rpt.rpt_data !== 8'd0) begin n_fail++; $display("FAIL order_empty_data got %0d want 0", rpt.rpt_data); end
  endtask

  task automatic test_drop_window;
    win_len = 8'd7; rpt.rpt_ready = 1'b1; hit = 1'b1; enable = 1'b1;
    tick; tick; tick;   // transition, window cycles 0 and 1
    enable = 1'b0;      // fall in window cycle 2
    tick; tick;
    n_checks++; if (rpt.rpt_valid !== 1'b0 || level !== 3'd0) begin n_fail++; $display("FAIL drop_no_push valid %b level %0d want 0 0", rpt.rpt_valid, level); end
    enable = 1'b1; hit = 1'b0;
    sb.push_back(8'd2);
    tick;
    for (int c = 0; c < 8; c++) begin
      hit = (c == 0 || c == 7);
      if (c == 7) begin
        n_checks++; if (rpt.rpt_valid !== 1'b0) begin n_fail++; $display("FAIL drop_short_window got valid %b want 0", rpt.rpt_valid); end
      end
      tick;
    end
    exp_d = sb.pop_front();
    n_checks++; if (rpt.rpt_valid !== 1'b1 || rpt.rpt_data !== exp_d) begin n_fail++; $display("FAIL drop_fresh_window got valid %b data %0d want 1 %0d", rpt.rpt_valid, rpt.rpt_data, exp_d); end
    enable = 1'b0; hit = 1'b0;
    tick;
  endtask

  task automatic test_reset_midop;
    win_len = 8'd0; rpt.rpt_ready = 1'b0; hit = 1'b1; enable = 1'b1;
    tick; tick; tick; tick;
    n_checks++; if (rpt.rpt_valid !== 1'b1 || level !== 3'd3) begin n_fail++; $display("FAIL rst_pre valid %b level %0d want 1 3", rpt.rpt_valid, level); end
    reset_n = 1'b0; rpt.rpt_ready = 1'b1; clr_ovf = 1'b1;
    tick;
    reset_n = 1'b1; rpt.rpt_ready = 1'b0; clr_ovf = 1'b0;
    n_checks++; if (rpt.rpt_valid !== 1'b0 || rpt.rpt_data !== 8'd0) begin n_fail++; $display("FAIL rst_out valid %b data %0d want 0 0", rpt.rpt_valid, rpt.rpt_data); end
    n_checks++; if (level !== 3'd0 || ovf !== 1'b0) begin n_fail++; $display("FAIL rst_state level %0d ovf %b want 0 0", level, ovf); end
    tick;  // FSM was in IDLE: this is the uncounted transition
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL rst_idle level %0d want 0", level); end
    tick;
    n_checks++; if (level !== 3'd1) begin n_fail++; $display("FAIL rst_resume level %0d want 1", level); end
    enable = 1'b0; hit = 1'b0; rpt.rpt_ready = 1'b1;
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_saturate;
    test_overflow;
    test_order;
    test_drop_window;
    test_reset_midop;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
